// File: rtl/gumnut_data_responder.sv
// Gumnut data-bus responder: classic-cycle Wishbone slave with a data RAM
// and a programmable number of wait states before the single-cycle ack.
module gumnut_data_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              busy_o
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                ack_q;
  logic                busy_q;
  logic                dat_zero_q;   // dat_o forced to zero (after reset or unmapped load)
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wdat_q;
  logic                we_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_q;

  logic                accept_d;
  logic                to_ack_d;
  logic [ADDR_W-1:0]   rd_adr_d;
  logic                rd_we_d;
  logic                rd_map_d;
  logic                rd_en_d;
  logic                wr_en_d;
  logic                map_q_d;

  // Decode the transition into ACK and the RAM read/write strobes
  always_comb begin
    accept_d = (state_q == ST_IDLE) && cyc_i && stb_i;
    to_ack_d = (accept_d && (WS_L == 4'd0)) ||
               ((state_q == ST_WAIT) && cyc_i && (cnt_q == 4'd1));
    // In IDLE (zero wait states) the request is read straight off the bus,
    // otherwise from the latched copy
    rd_adr_d = (state_q == ST_IDLE) ? adr_i : adr_q;
    rd_we_d  = (state_q == ST_IDLE) ? we_i  : we_q;
    rd_map_d = (32'(rd_adr_d) < DEPTH_U);
    rd_en_d  = to_ack_d && !rd_we_d && rd_map_d && !rst;
    map_q_d  = (32'(adr_q) < DEPTH_U);
    // The store commits on the edge leaving ACK unless reset cancels it
    wr_en_d  = (state_q == ST_ACK) && we_q && map_q_d && !rst;
  end

  // Data RAM: write on ACK exit, registered read on the edge entering ACK
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[adr_q[IDX_W-1:0]] <= wdat_q;
    end
    if (rd_en_d) begin
      rd_q <= mem_q[rd_adr_d[IDX_W-1:0]];
    end
  end

  // Bus handshake FSM with registered ack/busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      dat_zero_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (accept_d) begin
            adr_q  <= adr_i;
            wdat_q <= dat_i;
            we_q   <= we_i;
            cnt_q  <= WS_L;
            busy_q <= 1'b1;
            if (to_ack_d) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              if (!we_i) begin
                dat_zero_q <= !rd_map_d;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!cyc_i) begin
            // Master abandoned the cycle: no ack, no write
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (to_ack_d) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              if (!we_q) begin
                dat_zero_q <= !rd_map_d;
              end
            end
          end
        end
        ST_ACK: begin
          // Transfer is complete regardless of cyc_i
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign dat_o  = dat_zero_q ? '0 : rd_q;

endmodule

// File: doc/gumnut_data_responder.md
Name: gumnut_data_responder

Overview:
- Wishbone-style classic-cycle responder (slave) for the Gumnut data bus, sitting on the data side of the processor.
- Answers the control unit's data_cyc_o / data_stb_o / data_we_o requests with a data-memory access and a single-cycle ack.
- Drives data_ack_i back into the control unit, which holds in its memory state until that ack arrives.
- Contains the data RAM and a programmable wait-state counter so controller stall paths get exercised.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are unmapped.
- WAIT_STATES, 1, extra cycles inserted before ack, range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- cyc_i  input  1  bus cycle active (from data_cyc_o).
- stb_i  input  1  strobe, request valid (from data_stb_o).
- we_i  input  1  1 = store (stm), 0 = load (ldm).
- adr_i  input  ADDR_W  word address.
- dat_i  input  DATA_W  store data.
- dat_o  output  DATA_W  load data, valid while ack_o=1.
- ack_o  output  1  transfer complete, one-cycle pulse (to data_ack_i).
- busy_o  output  1  request accepted and not yet acked.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, wait counter=0, ack_o=0, busy_o=0, dat_o=0. RAM contents are not cleared and are retained across reset.
- States:
  - IDLE: if cyc_i & stb_i, latch adr_i, dat_i, we_i and load the counter with WAIT_STATES. Go to ACK if WAIT_STATES==0, else WAIT.
  - WAIT: decrement the counter each cycle; when the counter reaches 1 and is decremented, go to ACK. If cyc_i==0 on any WAIT cycle, abort: go to IDLE, no RAM write, no ack.
  - ACK: ack_o=1 for exactly this cycle. The store commits to RAM at the end of this cycle (posedge leaving ACK); load data is presented on dat_o. Next state is always IDLE.
- Latency: ack_o is high in cycle N+1+WAIT_STATES, where N is the cycle in which cyc_i&stb_i is first sampled high in IDLE. WAIT_STATES=0 gives ack in the cycle right after the request.
- Latched request: adr, dat and we are sampled only at acceptance. Changes on adr_i/dat_i/we_i during WAIT/ACK are ignored.
- dat_o:
  - On ACK for a load, equals RAM[latched adr], or 0 if unmapped.
  - For a store, dat_o holds its previous value.
  - Outside ACK, dat_o holds its last value (not required to be 0).
- Unmapped address (>= DEPTH): normal wait/ack timing; store discarded; load returns 0.
- Back-to-back: the IDLE state after ACK is mandatory, so the minimum request spacing is 1 idle cycle. A stb_i still high in that IDLE cycle is treated as a new request (the master must drop stb in the cycle following ack).
- cyc_i dropping during ACK: the ack still pulses and the store still commits; the transfer is already complete.
- busy_o=1 in WAIT and ACK, 0 in IDLE.
- stb_i with cyc_i=0 in IDLE: ignored.
- rst during WAIT/ACK: return to IDLE next cycle, no ack, no write (a store in ACK with rst=1 is dropped).
- No error or retry signalling; every accepted, non-aborted request produces exactly one ack.

Test Plan:
- Store then load, WAIT_STATES=1: store adr=0x10 dat=0xA5, ack 2 cycles after stb; then load adr=0x10 -> ack 2 cycles after stb with dat_o=0xA5.
- WAIT_STATES=0 and WAIT_STATES=3, load adr=0x00 preloaded 0x3C:
  - ack in cycle N+1 (0 wait states) and N+4 (3 wait states).
  - ack high exactly 1 cycle; busy_o high from N+1 through the ack cycle.
- Abort: WAIT_STATES=3, store adr=0x20 dat=0x55, drop cyc_i on 2nd WAIT cycle -> no ack. A following load adr=0x20 returns the prior value (0x00 after an earlier write of 0x00).
- Unmapped access, DEPTH=128: store adr=0x80 dat=0xFF, then load adr=0x80 -> both acked with normal latency; load dat_o=0x00. RAM[0x00] is unchanged.
- Input stability and back-to-back, WAIT_STATES=2:
  - Change adr_i/dat_i during WAIT -> original latched values are used.
  - Hold stb_i high through ACK+1 -> second ack arrives 4 cycles after the first.
- Reset mid-transfer: rst=1 during WAIT of store adr=0x30 dat=0x77 -> ack_o=0, busy_o=0 next cycle; load adr=0x30 returns the old value; previously stored 0xA5 at 0x10 survives.
